tt_loader: RTL and testbench

Front-end stage for the clocked Möbius transform core. It accepts a Boolean function's truth table as a stream of W-bit words over a valid/ready handshake and assembles the words into one N-bit vector. It then presents that vector, held stable, to the transform core's `inputs` port with a valid/ready handshake. It also performs frame checking and, optionally, an incremental Hamming-weight count. An odd weight indicates algebraic degree log2_N.

---
 rtl/tt_loader.sv | 148 ++++++++++++++
 tb/tb_tt_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_loader.sv
`default_nettype none
// tt_loader: assembles a streamed truth table into one N-bit vector for the Mobius transform core.
// Define TT_LOADER_WEIGHT_EN to add the running Hamming weight output tt_weight.
module tt_loader #(
  parameter int N      = 2048,
  parameter int log2_N = 11,
  parameter int W      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [0:W-1] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [0:N-1] tt,
  output logic         tt_valid,
  input  logic         tt_ready,
  output logic         frame_err
`ifdef TT_LOADER_WEIGHT_EN
  ,
  output logic [log2_N:0] tt_weight
`endif
);

  localparam int WORDS = N / W;
  localparam int CW    = (log2_N > $clog2(W)) ? (log2_N - $clog2(W)) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] wcnt;
  logic          accept;
  logic          at_last;
  logic          wr_en;
  logic          release_frame;
  logic [0:W-1]  wr_data;

  assign accept  = in_valid && in_ready;
  assign at_last = (wcnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: begin
        if (accept) begin
          if (at_last) begin
            state_nxt = S_HOLD;
          end else if (in_last) begin
            state_nxt = S_PAD;
          end
        end
      end
      S_PAD: begin
        if (at_last) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (tt_ready) begin
          state_nxt = S_FILL;
        end
      end
      default: state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    tt_valid      = (state == S_HOLD);
    release_frame = (state == S_HOLD) && tt_ready;
    wr_en         = ((state == S_FILL) && accept) || (state == S_PAD);
    wr_data       = (state == S_PAD) ? '0 : in_data;
  end

  // in_ready is registered from the next state so it drops on the edge entering PAD/HOLD
  // and rises on the same edge that releases the held frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt      <= '0;
      in_ready  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      in_ready <= (state_nxt == S_FILL);
      if (release_frame) begin
        wcnt      <= '0;
        frame_err <= 1'b0;
      end else if (wr_en) begin
        wcnt <= at_last ? '0 : wcnt + CW'(1);
        if (state == S_FILL) begin
          if (at_last) begin
            frame_err <= !in_last;
          end else if (in_last) begin
            frame_err <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt <= '0;
    end else begin
      for (int k = 0; k < WORDS; k++) begin
        if (wr_en && (wcnt == CW'(k))) begin
          tt[k*W +: W] <= wr_data;
        end
      end
    end
  end

`ifdef TT_LOADER_WEIGHT_EN
  localparam int PW = $clog2(W) + 1;
  localparam int SW = log2_N + 1;

  logic [PW-1:0] pop;

  always_comb begin
    pop = '0;
    for (int j = 0; j < W; j++) begin
      pop = pop + PW'(in_data[j]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_weight <= '0;
    end else if (release_frame) begin
      tt_weight <= '0;
    end else if ((state == S_FILL) && accept) begin
      tt_weight <= tt_weight + SW'(pop);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tt_loader.sv
`default_nettype none
// tb_tt_loader: table-driven frame vectors plus hand-written reset and stall sequences.
module tb_tt_loader;

  localparam int N     = 2048;
  localparam int LOG2N = 11;
  localparam int W     = 32;
  localparam int WORDS = N / W;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b1;
  logic [0:W-1] in_data  = '0;
  logic         in_valid = 1'b0;
  logic         in_last  = 1'b0;
  logic         in_ready;
  logic [0:N-1] tt;
  logic         tt_valid;
  logic         tt_ready = 1'b0;
  logic         frame_err;
`ifdef TT_LOADER_WEIGHT_EN
  logic [LOG2N:0] tt_weight;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tt_loader #(.N(N), .log2_N(LOG2N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .tt       (tt),
    .tt_valid (tt_valid),
    .tt_ready (tt_ready),
    .frame_err(frame_err)
`ifdef TT_LOADER_WEIGHT_EN
    ,
    .tt_weight(tt_weight)
`endif
  );

  // pat: 0 = {W{k[0]}}, 1 = all ones, 2 = single bit at k%W; last = -1 means no in_last
  typedef struct {
    int pat;
    int last;
    bit rdy_fill;
    bit gap;
    int hold;
    bit exp_err;
    int exp_w;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [0:W-1] word_of(input int pat, input int k);
    logic [0:W-1] d;
    d = '0;
    case (pat)
      0:       d = {W{k[0]}};
      1:       d = '1;
      default: d[k % W] = 1'b1;
    endcase
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tt(input string nm, input logic [0:N-1] exp);
    total++;
    if (tt !== exp) begin
      bad++;
      for (int i = 0; i < WORDS; i++) begin
        if (tt[i*W +: W] !== exp[i*W +: W]) begin
          $display("FAIL %s: word %0d got %h want %h", nm, i, tt[i*W +: W], exp[i*W +: W]);
          break;
        end
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int nwords;
    int k;
    int guard;
    int c;
    bit rdy;
    bit stall_bad;
    logic [0:N-1] exp;
    nwords = (v.last >= 0) ? v.last + 1 : WORDS;
    exp = '0;
    for (int i = 0; i < nwords; i++) exp[i*W +: W] = word_of(v.pat, i);
    tt_ready = v.rdy_fill;
    k = 0;
    guard = 0;
    while (k < nwords && guard < 2000) begin
      in_valid = v.gap ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? word_of(v.pat, k) : W'($urandom);
      in_last  = in_valid ? (k == v.last) : 1'($urandom_range(0, 1));
      rdy = in_ready;
      @(posedge clk); #1;
      if (in_valid && rdy) k++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk($sformatf("v%0d words_accepted", id), k, nwords);
    c = 0;
    while (!tt_valid && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk($sformatf("v%0d pad_cycles", id), c,
        (v.last >= 0 && v.last < WORDS - 1) ? WORDS - 1 - v.last : 0);
    chk($sformatf("v%0d tt_valid", id), tt_valid, 1);
    chk_tt($sformatf("v%0d tt", id), exp);
    chk($sformatf("v%0d frame_err", id), frame_err, v.exp_err);
    chk($sformatf("v%0d in_ready_hold", id), in_ready, 0);
`ifdef TT_LOADER_WEIGHT_EN
    chk($sformatf("v%0d tt_weight", id), tt_weight, v.exp_w);
`endif
    stall_bad = 1'b0;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      if (tt !== exp || tt_valid !== 1'b1 || in_ready !== 1'b0) stall_bad = 1'b1;
    end
    if (v.hold > 0) chk($sformatf("v%0d hold_stable", id), stall_bad, 0);
    tt_ready = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("v%0d release valid/ready", id), {tt_valid, in_ready}, 2'b01);
    tt_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:N-1] zero;
    zero = '0;
    vecs[0] = '{0, 63, 1'b1, 1'b0, 0, 1'b0, 1024};
    vecs[1] = '{0, 63, 1'b0, 1'b0, 10, 1'b0, 1024};
    vecs[2] = '{1, 3, 1'b0, 1'b0, 0, 1'b1, 128};
    vecs[3] = '{1, -1, 1'b0, 1'b0, 0, 1'b1, 2048};
    vecs[4] = '{0, 63, 1'b0, 1'b0, 0, 1'b0, 1024};
    vecs[5] = '{2, 63, 1'b0, 1'b1, 3, 1'b0, 64};
    vecs[6] = '{2, 0, 1'b0, 1'b0, 0, 1'b1, 1};
    vecs[7] = '{2, 62, 1'b0, 1'b1, 0, 1'b1, 63};
    vecs[8] = '{0, 63, 1'b0, 1'b0, 0, 1'b0, 1024};

    #1 rst_n = 1'b0;
    #1;
    chk("reset in_ready", in_ready, 0);
    chk("reset tt_valid", tt_valid, 0);
    chk("reset frame_err", frame_err, 0);
    chk_tt("reset tt", zero);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("in_ready before first edge", in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready first edge", in_ready, 1);

    for (int v = 0; v < 8; v++) run_vec(vecs[v], v);

    // Reset in the middle of a fill discards the partial frame
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = '1;
      in_last  = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset in_ready", in_ready, 0);
    chk("midreset tt_valid", tt_valid, 0);
    chk_tt("midreset tt", zero);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midreset in_ready back", in_ready, 1);
    run_vec(vecs[8], 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
